// File: rtl/ipv4_pkg.sv
// Shared constants, FSM state type and helpers for the IPv4 receive path.
package ipv4_pkg;

  localparam int          IPV4_HDR_WORDS = 5;
  localparam logic [3:0]  IPV4_VERSION   = 4'd4;
  localparam logic [3:0]  IPV4_IHL_MIN   = 4'd5;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'd17;
  localparam logic [15:0] IPV4_HDR_BYTES = 16'd20;
  localparam logic [31:0] IPV4_BCAST     = 32'hFFFF_FFFF;

  // Byte offsets of the fields used, counted from the first header byte on the wire.
  localparam int OFF_VER_IHL = 0;
  localparam int OFF_TLEN    = 2;
  localparam int OFF_FLAGS   = 6;
  localparam int OFF_FRAG_LO = 7;
  localparam int OFF_PROTO   = 9;
  localparam int OFF_DST     = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_PLOAD,
    ST_DROP
  } ipv4_state_t;

  // Extract the byte at header offset 'off' from the 32-bit beat that carries it.
  function automatic logic [7:0] hdr_byte(input logic [31:0] w, input int off);
    return w[(off % 4) * 8 +: 8];
  endfunction

  // 16-bit ones' complement add with end-around carry.
  function automatic logic [15:0] ones_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

endpackage

// File: rtl/ipv4_csum.sv
// Running IPv4 header checksum: folds two big-endian 16-bit words per beat.
module ipv4_csum
  import ipv4_pkg::*;
(
  input  logic        clk,
  input  logic        nreset,
  input  logic        i_start,
  input  logic        i_add,
  input  logic [31:0] i_data,
  output logic        o_ok
);

  logic [15:0] r_sum;
  logic [15:0] w_base;
  logic [15:0] w_sum_next;

  // A start beat restarts the sum from zero instead of the running value.
  assign w_base     = i_start ? 16'h0000 : r_sum;
  assign w_sum_next = ones_add16(ones_add16(w_base, {i_data[7:0], i_data[15:8]}),
                                 {i_data[23:16], i_data[31:24]});
  // ok already includes the current beat so the last header word can be judged on arrival.
  assign o_ok       = (w_sum_next == 16'hFFFF);

  // Accumulator register, updated on every header beat.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_sum <= 16'h0000;
    end else if (i_add) begin
      r_sum <= w_sum_next;
    end
  end

endmodule

// File: rtl/ipv4_rx.sv
// IPv4 header stripper: validates the 20-byte header and forwards the UDP datagram.
module ipv4_rx
  import ipv4_pkg::*;
#(
  parameter int          DATA_W     = 32,
  parameter int          KEEP_W     = DATA_W / 8,
  parameter bit          CHECK_CSUM = 1'b1,
  parameter logic [31:0] LOCAL_IP   = 32'hC0A8_0002
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              valid_i,
  input  logic              last_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [KEEP_W-1:0] keep_i,
  input  logic              flush_i,
  output logic              valid_o,
  output logic              last_o,
  output logic [DATA_W-1:0] data_o,
  output logic [KEEP_W-1:0] keep_o,
  output logic              flush_o,
  output logic              drop_o
);

  localparam logic [2:0] HCNT_LAST = 3'(IPV4_HDR_WORDS - 1);

  ipv4_state_t       r_state, w_state_next;
  logic [2:0]        r_hcnt, w_hcnt_next;
  logic [15:0]       r_rem, w_rem_next;
  logic [15:0]       r_tlen, w_tlen_next;
  logic              r_bad, w_bad_next;
  logic              r_post_rst;
  logic              r_valid_o, w_valid_o_next;
  logic              r_last_o, w_last_o_next;
  logic [DATA_W-1:0] r_data_o, w_data_o_next;
  logic [KEEP_W-1:0] r_keep_o, w_keep_o_next;
  logic              r_flush_o, w_flush_o_next;
  logic              r_drop_o, w_drop_o_next;

  logic              w_csum_start, w_csum_add, w_csum_ok;
  logic [15:0]       w_tlen;
  logic [7:0]        w_ver_ihl, w_flags, w_frag_lo;
  logic [31:0]       w_dst;
  logic              w_word0_bad, w_word1_bad, w_word2_bad, w_dst_bad, w_hdr_fail;
  logic [KEEP_W-1:0] w_rem_mask;

  // Per-word field decode from the current beat.
  assign w_tlen      = {hdr_byte(data_i, OFF_TLEN), hdr_byte(data_i, OFF_TLEN + 1)};
  assign w_ver_ihl   = hdr_byte(data_i, OFF_VER_IHL);
  assign w_word0_bad = (w_ver_ihl[7:4] != IPV4_VERSION) || (w_ver_ihl[3:0] != IPV4_IHL_MIN) ||
                       (w_tlen < IPV4_HDR_BYTES);
  assign w_flags     = hdr_byte(data_i, OFF_FLAGS);
  assign w_frag_lo   = hdr_byte(data_i, OFF_FRAG_LO);
  // MF is bit 5 of the flags byte; the low 5 bits plus the next byte form the fragment offset.
  assign w_word1_bad = w_flags[5] || (w_flags[4:0] != 5'd0) || (w_frag_lo != 8'd0);
  assign w_word2_bad = (hdr_byte(data_i, OFF_PROTO) != IP_PROTO_UDP);
  assign w_dst       = {hdr_byte(data_i, OFF_DST),     hdr_byte(data_i, OFF_DST + 1),
                        hdr_byte(data_i, OFF_DST + 2), hdr_byte(data_i, OFF_DST + 3)};
  assign w_dst_bad   = (w_dst != LOCAL_IP) && (w_dst != IPV4_BCAST);
  assign w_hdr_fail  = r_bad || w_dst_bad || (CHECK_CSUM && !w_csum_ok);

  // Byte-lane mask for the final payload beat: lane gi is valid while rem > gi.
  genvar gi;
  generate
    for (gi = 0; gi < KEEP_W; gi++) begin : g_rem_mask
      assign w_rem_mask[gi] = (r_rem > 16'(gi));
    end
  endgenerate

  ipv4_csum u_csum (
    .clk     (clk),
    .nreset  (nreset),
    .i_start (w_csum_start),
    .i_add   (w_csum_add),
    .i_data  (data_i[31:0]),
    .o_ok    (w_csum_ok)
  );

  // Next-state and next-output logic for the header/payload FSM.
  always_comb begin
    w_state_next   = r_state;
    w_hcnt_next    = r_hcnt;
    w_rem_next     = r_rem;
    w_tlen_next    = r_tlen;
    w_bad_next     = r_bad;
    w_valid_o_next = 1'b0;
    w_last_o_next  = 1'b0;
    w_data_o_next  = '0;
    w_keep_o_next  = '0;
    w_flush_o_next = flush_i;
    w_drop_o_next  = 1'b0;
    w_csum_start   = 1'b0;
    w_csum_add     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (valid_i) begin
          if (r_post_rst) begin
            // Tail of a frame interrupted by reset: discard it silently.
            if (!last_i) w_state_next = ST_DROP;
          end else begin
            w_csum_start = 1'b1;
            w_csum_add   = 1'b1;
            w_tlen_next  = w_tlen;
            w_bad_next   = w_word0_bad;
            w_hcnt_next  = 3'd1;
            if (last_i) begin
              w_drop_o_next = 1'b1;
              w_hcnt_next   = 3'd0;
            end else begin
              w_state_next = ST_HDR;
            end
          end
        end
      end

      ST_HDR: begin
        if (valid_i) begin
          w_csum_add  = 1'b1;
          w_hcnt_next = r_hcnt + 3'd1;
          if (r_hcnt == HCNT_LAST) begin
            w_hcnt_next = 3'd0;
            if (w_hdr_fail) begin
              w_drop_o_next = 1'b1;
              w_state_next  = last_i ? ST_IDLE : ST_DROP;
            end else if (r_tlen == IPV4_HDR_BYTES) begin
              w_state_next = last_i ? ST_IDLE : ST_DROP;
            end else if (last_i) begin
              w_drop_o_next = 1'b1;
              w_state_next  = ST_IDLE;
            end else begin
              w_rem_next   = r_tlen - IPV4_HDR_BYTES;
              w_state_next = ST_PLOAD;
            end
          end else if (last_i) begin
            w_drop_o_next = 1'b1;
            w_hcnt_next   = 3'd0;
            w_state_next  = ST_IDLE;
          end else begin
            w_bad_next = r_bad || ((r_hcnt == 3'd1) && w_word1_bad) ||
                                  ((r_hcnt == 3'd2) && w_word2_bad);
          end
        end
      end

      ST_PLOAD: begin
        if (valid_i) begin
          w_valid_o_next = 1'b1;
          w_data_o_next  = data_i;
          if (r_rem <= 16'(KEEP_W)) begin
            w_last_o_next = 1'b1;
            w_keep_o_next = w_rem_mask;
            w_rem_next    = 16'd0;
            w_state_next  = last_i ? ST_IDLE : ST_DROP;
          end else if (last_i) begin
            // Frame ended before Total Length was reached: close and flag it.
            w_last_o_next  = 1'b1;
            w_keep_o_next  = keep_i;
            w_flush_o_next = 1'b1;
            w_rem_next     = 16'd0;
            w_state_next   = ST_IDLE;
          end else begin
            w_keep_o_next = '1;
            w_rem_next    = r_rem - 16'(KEEP_W);
          end
        end
        if (flush_i) begin
          w_rem_next   = 16'd0;
          w_state_next = ST_IDLE;
        end
      end

      ST_DROP: begin
        if (flush_i || (valid_i && last_i)) w_state_next = ST_IDLE;
      end

      default: w_state_next = ST_IDLE;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_state    <= ST_IDLE;
      r_hcnt     <= 3'd0;
      r_rem      <= 16'd0;
      r_tlen     <= 16'd0;
      r_bad      <= 1'b0;
      r_post_rst <= 1'b1;
      r_valid_o  <= 1'b0;
      r_last_o   <= 1'b0;
      r_data_o   <= '0;
      r_keep_o   <= '0;
      r_flush_o  <= 1'b0;
      r_drop_o   <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_hcnt     <= w_hcnt_next;
      r_rem      <= w_rem_next;
      r_tlen     <= w_tlen_next;
      r_bad      <= w_bad_next;
      r_post_rst <= 1'b0;
      r_valid_o  <= w_valid_o_next;
      r_last_o   <= w_last_o_next;
      r_data_o   <= w_data_o_next;
      r_keep_o   <= w_keep_o_next;
      r_flush_o  <= w_flush_o_next;
      r_drop_o   <= w_drop_o_next;
    end
  end

  assign valid_o = r_valid_o;
  assign last_o  = r_last_o;
  assign data_o  = r_data_o;
  assign keep_o  = r_keep_o;
  assign flush_o = r_flush_o;
  assign drop_o  = r_drop_o;

endmodule

// File: tb/tb_ipv4_rx.sv
// Directed scoreboard bench for ipv4_rx (checksum-checking and checksum-ignoring instances).
module tb_ipv4_rx;

  localparam logic [31:0] LOCAL  = 32'hC0A8_0002;
  localparam logic [31:0] PAY    = 32'hA0B0_C000;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        valid_i = 1'b0, last_i = 1'b0, flush_i = 1'b0;
  logic [31:0] data_i = 32'h0;
  logic [3:0]  keep_i = 4'h0;

  logic        valid_o, last_o, flush_o, drop_o;
  logic [31:0] data_o;
  logic [3:0]  keep_o;
  logic        nc_valid_o, nc_last_o, nc_flush_o, nc_drop_o;
  logic [31:0] nc_data_o;
  logic [3:0]  nc_keep_o;

  always #5 clk = ~clk;

  ipv4_rx #(.CHECK_CSUM(1'b1), .LOCAL_IP(LOCAL)) dut (
    .clk(clk), .nreset(nreset), .valid_i(valid_i), .last_i(last_i), .data_i(data_i),
    .keep_i(keep_i), .flush_i(flush_i), .valid_o(valid_o), .last_o(last_o),
    .data_o(data_o), .keep_o(keep_o), .flush_o(flush_o), .drop_o(drop_o)
  );

  ipv4_rx #(.CHECK_CSUM(1'b0), .LOCAL_IP(LOCAL)) dut_nc (
    .clk(clk), .nreset(nreset), .valid_i(valid_i), .last_i(last_i), .data_i(data_i),
    .keep_i(keep_i), .flush_i(flush_i), .valid_o(nc_valid_o), .last_o(nc_last_o),
    .data_o(nc_data_o), .keep_o(nc_keep_o), .flush_o(nc_flush_o), .drop_o(nc_drop_o)
  );

  typedef struct packed {
    logic        last;
    logic [31:0] data;
    logic [3:0]  keep;
    logic        flush;
  } beat_t;

  beat_t exp_q[$];
  int n_assert = 0, n_fail = 0;
  int beats_seen = 0, drops_seen = 0, nc_beats = 0, nc_drops = 0;
  int base_beats = 0, base_drops = 0;

  // Output monitor: every output beat is popped from the scoreboard and compared.
  always @(negedge clk) begin
    beat_t o, e;
    if (drop_o) drops_seen++;
    if (nc_valid_o) nc_beats++;
    if (nc_drop_o) nc_drops++;
    if (valid_o) begin
      beats_seen++;
      o = {last_o, data_o, keep_o, flush_o};
      n_assert++;
      assert (exp_q.size() > 0) else begin
        n_fail++;
        $error("FAIL unexpected_beat: observed data=%h last=%b keep=%h, expected no beat",
               data_o, last_o, keep_o);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_assert++;
        assert (o === e) else begin
          n_fail++;
          $error("FAIL beat: observed last=%b data=%h keep=%h flush=%b, expected last=%b data=%h keep=%h flush=%b",
                 o.last, o.data, o.keep, o.flush, e.last, e.data, e.keep, e.flush);
        end
        $display("beat data=%h keep=%h last=%b flush=%b", o.data, o.keep, o.last, o.flush);
      end
    end
  end

  task automatic drive(input logic [31:0] d, input logic l, input logic [3:0] k, input logic f);
    @(negedge clk);
    valid_i = 1'b1; data_i = d; last_i = l; keep_i = k; flush_i = f;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid_i = 1'b0; data_i = 32'h0; last_i = 1'b0; keep_i = 4'h0; flush_i = 1'b0;
    end
  endtask

  task automatic push(input logic l, input logic [31:0] d, input logic [3:0] k, input logic f);
    exp_q.push_back({l, d, k, f});
  endtask

  // Header words built from wire byte order (first byte in bits 7:0).
  task automatic send_hdr(input logic [15:0] tlen, input logic [7:0] proto,
                          input logic [15:0] csum, input logic [31:0] dst);
    drive({tlen[7:0], tlen[15:8], 8'h00, 8'h45}, 1'b0, 4'hF, 1'b0);
    drive(32'h0040_0000, 1'b0, 4'hF, 1'b0);
    drive({csum[7:0], csum[15:8], proto, 8'h40}, 1'b0, 4'hF, 1'b0);
    drive(32'h0100_A8C0, 1'b0, 4'hF, 1'b0);
    drive({dst[7:0], dst[15:8], dst[23:16], dst[31:24]}, 1'b0, 4'hF, 1'b0);
  endtask

  task automatic send_pay(input int n, input logic exp_out);
    for (int i = 0; i < n; i++) begin
      drive(PAY + 32'(i), (i == n - 1), 4'hF, 1'b0);
      if (exp_out) push((i == n - 1), PAY + 32'(i), 4'hF, 1'b0);
    end
  endtask

  task automatic good_frame();
    send_hdr(16'h0020, 8'h11, 16'hB979, LOCAL);
    send_pay(3, 1'b1);
  endtask

  task automatic begin_frame();
    base_beats = beats_seen;
    base_drops = drops_seen;
  endtask

  task automatic end_frame(input string tag, input int eb, input int ed);
    idle(3);
    n_assert++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL %s_pending: observed %0d beats still expected, expected 0", tag, exp_q.size());
    end
    n_assert++;
    assert (beats_seen - base_beats == eb) else begin
      n_fail++;
      $error("FAIL %s_beats: observed %0d, expected %0d", tag, beats_seen - base_beats, eb);
    end
    n_assert++;
    assert (drops_seen - base_drops == ed) else begin
      n_fail++;
      $error("FAIL %s_drops: observed %0d, expected %0d", tag, drops_seen - base_drops, ed);
    end
    $display("frame %s: beats=%0d drops=%0d", tag, beats_seen - base_beats, drops_seen - base_drops);
    exp_q.delete();
  endtask

  task automatic check_zero(input string tag);
    n_assert++;
    assert ({valid_o, last_o, data_o, keep_o, flush_o, drop_o} === 40'h0) else begin
      n_fail++;
      $error("FAIL %s: observed valid=%b last=%b data=%h keep=%h flush=%b drop=%b, expected all 0",
             tag, valid_o, last_o, data_o, keep_o, flush_o, drop_o);
    end
  endtask

  initial begin
    int nc_b, nc_d;

    // Reset state
    repeat (3) @(negedge clk);
    check_zero("reset_outputs");
    nreset = 1'b1;
    idle(2);

    // 1. Good frame
    begin_frame();
    good_frame();
    end_frame("good", 3, 0);

    // 2. Padding trim: 10-byte payload, then 8 padding words
    begin_frame();
    send_hdr(16'h001E, 8'h11, 16'hB97B, LOCAL);
    drive(PAY + 32'd0, 1'b0, 4'hF, 1'b0); push(1'b0, PAY + 32'd0, 4'hF, 1'b0);
    drive(PAY + 32'd1, 1'b0, 4'hF, 1'b0); push(1'b0, PAY + 32'd1, 4'hF, 1'b0);
    drive(PAY + 32'd2, 1'b0, 4'hF, 1'b0); push(1'b1, PAY + 32'd2, 4'h3, 1'b0);
    for (int i = 0; i < 8; i++) drive(32'hEEEE_0000 + 32'(i), (i == 7), 4'hF, 1'b0);
    end_frame("pad_trim", 3, 0);

    // 3a/3d. Bad checksum: rejected when checked, accepted when ignored
    begin_frame();
    nc_b = nc_beats;
    nc_d = nc_drops;
    send_hdr(16'h0020, 8'h11, 16'hB978, LOCAL);
    send_pay(3, 1'b0);
    end_frame("csum_bad", 0, 1);
    n_assert++;
    assert (nc_beats - nc_b == 3) else begin
      n_fail++;
      $error("FAIL csum_ignored_beats: observed %0d, expected 3", nc_beats - nc_b);
    end
    n_assert++;
    assert (nc_drops - nc_d == 0) else begin
      n_fail++;
      $error("FAIL csum_ignored_drops: observed %0d, expected 0", nc_drops - nc_d);
    end

    // 3b. Protocol TCP (checksum corrected so only the protocol is wrong)
    begin_frame();
    send_hdr(16'h0020, 8'h06, 16'hB984, LOCAL);
    send_pay(3, 1'b0);
    end_frame("proto_tcp", 0, 1);

    // 3c. Wrong destination (checksum corrected)
    begin_frame();
    send_hdr(16'h0020, 8'h11, 16'hB978, 32'hC0A8_0003);
    send_pay(3, 1'b0);
    end_frame("dst_other", 0, 1);

    // 4. flush_i on the 2nd payload beat; 3rd beat then lands in IDLE as a one-beat frame
    begin_frame();
    send_hdr(16'h0020, 8'h11, 16'hB979, LOCAL);
    drive(PAY + 32'd0, 1'b0, 4'hF, 1'b0); push(1'b0, PAY + 32'd0, 4'hF, 1'b0);
    drive(PAY + 32'd1, 1'b0, 4'hF, 1'b1); push(1'b0, PAY + 32'd1, 4'hF, 1'b1);
    drive(PAY + 32'd2, 1'b1, 4'hF, 1'b0);
    end_frame("flush", 2, 1);
    begin_frame();
    good_frame();
    end_frame("after_flush", 3, 0);

    // 5. Truncated frame: Total Length 64, last_i on 2nd payload beat
    begin_frame();
    send_hdr(16'h0040, 8'h11, 16'hB959, LOCAL);
    drive(PAY + 32'd0, 1'b0, 4'hF, 1'b0); push(1'b0, PAY + 32'd0, 4'hF, 1'b0);
    drive(PAY + 32'd1, 1'b1, 4'h7, 1'b0); push(1'b1, PAY + 32'd1, 4'h7, 1'b1);
    end_frame("truncated", 2, 0);

    // 6. Back-to-back frames, then reset mid-payload of the second
    begin_frame();
    good_frame();
    send_hdr(16'h001E, 8'h11, 16'hB97B, LOCAL);
    drive(PAY + 32'd10, 1'b0, 4'hF, 1'b0); push(1'b0, PAY + 32'd10, 4'hF, 1'b0);
    drive(PAY + 32'd11, 1'b0, 4'hF, 1'b0); push(1'b0, PAY + 32'd11, 4'hF, 1'b0);
    @(negedge clk);
    nreset = 1'b0; valid_i = 1'b1; data_i = PAY + 32'd12; last_i = 1'b0; keep_i = 4'hF;
    @(negedge clk);
    check_zero("after_reset_outputs");
    nreset = 1'b1; data_i = PAY + 32'd13;
    drive(PAY + 32'd14, 1'b0, 4'hF, 1'b0);
    drive(PAY + 32'd15, 1'b1, 4'hF, 1'b0);
    end_frame("b2b_reset", 5, 0);
    begin_frame();
    good_frame();
    end_frame("post_reset_good", 3, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
